jtag_bscan_tap: RTL and testbench

Parametrised successor to the single-GPIO JTAG top: one block containing a full 16-state TAP controller, a 4-bit instruction register, a BYPASS register, an optional 32-bit IDCODE register and a boundary-scan chain sized by `GPIO_COUNT`. It sits between the GPIO pads and the digital core. All logic runs on `internal_clk` and advances only on the synchronised TCK strobe produced by the existing `clock_sync` instance.

---
 rtl/jtag_pkg.sv | 59 +++++
 rtl/jtag_tap_fsm.sv | 78 +++++++
 rtl/jtag_bscan_tap.sv | 143 ++++++++++++++
 tb/tb_jtag_bscan_tap.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, instruction opcodes and data-register decode.
// Build option JTAG_BSCAN_IDCODE_EN adds the IDCODE register and makes it the reset instruction.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_BOUNDARY,
    DR_IDCODE
  } dr_sel_t;

  localparam int IR_WIDTH = 4;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST         = 4'b0001;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE_PRELOAD = 4'b0010;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE         = 4'b0011;
  localparam logic [IR_WIDTH-1:0] OP_BYPASS         = 4'b1111;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE        = 4'b0101;

`ifdef JTAG_BSCAN_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = OP_BYPASS;
`endif

  // Undefined opcodes (and IDCODE when the register is absent) fall back to BYPASS.
  function automatic dr_sel_t decode_dr(input logic [IR_WIDTH-1:0] op);
    dr_sel_t sel;
    sel = DR_BYPASS;
    if (op == OP_EXTEST || op == OP_SAMPLE_PRELOAD) begin
      sel = DR_BOUNDARY;
    end
`ifdef JTAG_BSCAN_IDCODE_EN
    else if (op == OP_IDCODE) begin
      sel = DR_IDCODE;
    end
`endif
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state register advanced by the synchronised TCK strobe,
// plus per-strobe capture/shift/update pulses for the IR and DR paths.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tck_en,
  input  logic       tms,
  output tap_state_t state,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       tlr_enter
);

  tap_state_t state_q, state_d;
  logic       armed_q, armed_d;
  logic       strobe;

  // The first clock after reset release never acts on a strobe.
  assign strobe = tck_en & armed_q;
  assign state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TEST_LOGIC_RESET;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    armed_d    = 1'b1;
    state_d    = state_q;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    tlr_enter  = 1'b0;
    if (strobe) begin
      case (state_q)
        TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
        CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        default:          state_d = TEST_LOGIC_RESET;
      endcase
      capture_ir = (state_q == CAPTURE_IR);
      shift_ir   = (state_q == SHIFT_IR);
      update_ir  = (state_q == UPDATE_IR);
      capture_dr = (state_q == CAPTURE_DR);
      shift_dr   = (state_q == SHIFT_DR);
      update_dr  = (state_q == UPDATE_DR);
      tlr_enter  = (state_d == TEST_LOGIC_RESET);
    end
  end

endmodule

// File: rtl/jtag_bscan_tap.sv
// Boundary-scan TAP between GPIO pads and core: IR, BYPASS, optional IDCODE, 2*GPIO_COUNT chain.
// Build option JTAG_BSCAN_IDCODE_EN enables the IDCODE register.
module jtag_bscan_tap
  import jtag_pkg::*;
#(
  parameter int          GPIO_COUNT   = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                  internal_clk,
  input  logic                  jtag_rstn,
  input  logic                  jtag_tck_enable,
  input  logic                  jtag_mode,
  input  logic                  jtag_tdi,
  output logic                  jtag_tdo,
  input  logic [GPIO_COUNT-1:0] gpio_pad_in,
  output logic [GPIO_COUNT-1:0] gpio_pad_out,
  input  logic [GPIO_COUNT-1:0] core_gpio_out,
  output logic [GPIO_COUNT-1:0] core_gpio_in,
  output logic                  jtag_extest_active
);

  localparam int BSR_LEN = 2 * GPIO_COUNT;

  tap_state_t tap_state;
  logic       capture_ir, shift_ir, update_ir;
  logic       capture_dr, shift_dr, update_dr, tlr_enter;
  dr_sel_t    dr_sel;
  logic       extest;

  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [BSR_LEN-1:0]  bsr_shift_q, bsr_shift_d;
  logic [BSR_LEN-1:0]  bsr_upd_q, bsr_upd_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
`ifdef JTAG_BSCAN_IDCODE_EN
  logic [31:0]         id_shift_q, id_shift_d;
`else
  logic                unused_idcode;
  assign unused_idcode = ^IDCODE_VALUE;
`endif

  jtag_tap_fsm u_tap_fsm (
    .clk        (internal_clk),
    .rst_n      (jtag_rstn),
    .tck_en     (jtag_tck_enable),
    .tms        (jtag_mode),
    .state      (tap_state),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .tlr_enter  (tlr_enter)
  );

  assign dr_sel = decode_dr(ir_q);
  assign extest = (ir_q == OP_EXTEST);

  always_ff @(posedge internal_clk or negedge jtag_rstn) begin
    if (!jtag_rstn) begin
      ir_shift_q  <= '0;
      ir_q        <= IR_RESET;
      bsr_shift_q <= '0;
      bsr_upd_q   <= '0;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
`ifdef JTAG_BSCAN_IDCODE_EN
      id_shift_q  <= '0;
`endif
    end else begin
      ir_shift_q  <= ir_shift_d;
      ir_q        <= ir_d;
      bsr_shift_q <= bsr_shift_d;
      bsr_upd_q   <= bsr_upd_d;
      bypass_q    <= bypass_d;
      tdo_q       <= tdo_d;
`ifdef JTAG_BSCAN_IDCODE_EN
      id_shift_q  <= id_shift_d;
`endif
    end
  end

  // All serial paths shift toward bit 0, with TDI entering the top bit.
  always_comb begin
    ir_shift_d  = ir_shift_q;
    ir_d        = ir_q;
    bsr_shift_d = bsr_shift_q;
    bsr_upd_d   = bsr_upd_q;
    bypass_d    = bypass_q;
`ifdef JTAG_BSCAN_IDCODE_EN
    id_shift_d  = id_shift_q;
`endif
    if (capture_ir) ir_shift_d = IR_CAPTURE;
    if (shift_ir)   ir_shift_d = {jtag_tdi, ir_shift_q[IR_WIDTH-1:1]};
    if (update_ir)  ir_d       = ir_shift_q;
    if (capture_dr) begin
      case (dr_sel)
        DR_BOUNDARY: bsr_shift_d = {core_gpio_out, gpio_pad_in};
`ifdef JTAG_BSCAN_IDCODE_EN
        DR_IDCODE:   id_shift_d  = IDCODE_VALUE | 32'h0000_0001;
`endif
        default:     bypass_d    = 1'b0;
      endcase
    end
    if (shift_dr) begin
      case (dr_sel)
        DR_BOUNDARY: bsr_shift_d = {jtag_tdi, bsr_shift_q[BSR_LEN-1:1]};
`ifdef JTAG_BSCAN_IDCODE_EN
        DR_IDCODE:   id_shift_d  = {jtag_tdi, id_shift_q[31:1]};
`endif
        default:     bypass_d    = jtag_tdi;
      endcase
    end
    if (update_dr && dr_sel == DR_BOUNDARY) bsr_upd_d = bsr_shift_q;
    if (tlr_enter) begin
      ir_d      = IR_RESET;
      bsr_upd_d = '0;
    end
  end

  always_comb begin
    tdo_d = 1'b0;
    if (tap_state == SHIFT_IR) begin
      tdo_d = ir_shift_q[0];
    end else if (tap_state == SHIFT_DR) begin
      case (dr_sel)
        DR_BOUNDARY: tdo_d = bsr_shift_q[0];
`ifdef JTAG_BSCAN_IDCODE_EN
        DR_IDCODE:   tdo_d = id_shift_q[0];
`endif
        default:     tdo_d = bypass_q;
      endcase
    end
  end

  assign jtag_tdo           = tdo_q;
  assign jtag_extest_active = extest;
  assign gpio_pad_out       = extest ? bsr_upd_q[BSR_LEN-1:GPIO_COUNT] : core_gpio_out;
  assign core_gpio_in       = extest ? bsr_upd_q[GPIO_COUNT-1:0]       : gpio_pad_in;

endmodule

// File: tb/tb_jtag_bscan_tap.sv
// Self-checking bench for jtag_bscan_tap: directed scans plus a random TMS/TDI walk
// compared against a behavioural TAP/register model.
module tb_jtag_bscan_tap;

  localparam int          N   = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef JTAG_BSCAN_IDCODE_EN
  localparam bit         HAS_ID = 1'b1;
  localparam logic [3:0] M_DEF  = 4'h3;
`else
  localparam bit         HAS_ID = 1'b0;
  localparam logic [3:0] M_DEF  = 4'hF;
`endif

  localparam int T_RESET = 0,  T_IDLE = 1,   T_SEL_DR = 2,   T_CAP_DR = 3;
  localparam int T_SHIFT_DR = 4, T_EX1_DR = 5, T_PAUSE_DR = 6, T_EX2_DR = 7;
  localparam int T_UPD_DR = 8, T_SEL_IR = 9, T_CAP_IR = 10,  T_SHIFT_IR = 11;
  localparam int T_EX1_IR = 12, T_PAUSE_IR = 13, T_EX2_IR = 14, T_UPD_IR = 15;

  // Successor of each state for TMS=0 / TMS=1.
  int graph [16][2] = '{
    '{T_IDLE,     T_RESET},  '{T_IDLE,     T_SEL_DR}, '{T_CAP_DR,   T_SEL_IR},
    '{T_SHIFT_DR, T_EX1_DR}, '{T_SHIFT_DR, T_EX1_DR}, '{T_PAUSE_DR, T_UPD_DR},
    '{T_PAUSE_DR, T_EX2_DR}, '{T_SHIFT_DR, T_UPD_DR}, '{T_IDLE,     T_SEL_DR},
    '{T_CAP_IR,   T_RESET},  '{T_SHIFT_IR, T_EX1_IR}, '{T_SHIFT_IR, T_EX1_IR},
    '{T_PAUSE_IR, T_UPD_IR}, '{T_PAUSE_IR, T_EX2_IR}, '{T_SHIFT_IR, T_UPD_IR},
    '{T_IDLE,     T_SEL_DR}
  };

  logic         internal_clk = 1'b0;
  logic         jtag_rstn, jtag_tck_enable, jtag_mode, jtag_tdi;
  logic         jtag_tdo, jtag_extest_active;
  logic [N-1:0] gpio_pad_in, gpio_pad_out, core_gpio_out, core_gpio_in;
  logic         tdo1, ext1;
  logic [0:0]   pad_in1, pad_out1, core_out1, core_in1;

  int vectors = 0;
  int miscompares = 0;

  int           ms;
  logic [3:0]   m_irs, m_ins;
  logic [2*N-1:0] m_bsr, m_upd;
  logic [31:0]  m_id;
  logic         m_byp;

  always #5 internal_clk = ~internal_clk;

  jtag_bscan_tap #(.GPIO_COUNT(N), .IDCODE_VALUE(IDV)) dut (
    .internal_clk(internal_clk), .jtag_rstn(jtag_rstn), .jtag_tck_enable(jtag_tck_enable),
    .jtag_mode(jtag_mode), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .gpio_pad_in(gpio_pad_in), .gpio_pad_out(gpio_pad_out),
    .core_gpio_out(core_gpio_out), .core_gpio_in(core_gpio_in),
    .jtag_extest_active(jtag_extest_active)
  );

  jtag_bscan_tap #(.GPIO_COUNT(1), .IDCODE_VALUE(IDV)) dut1 (
    .internal_clk(internal_clk), .jtag_rstn(jtag_rstn), .jtag_tck_enable(jtag_tck_enable),
    .jtag_mode(jtag_mode), .jtag_tdi(jtag_tdi), .jtag_tdo(tdo1),
    .gpio_pad_in(pad_in1), .gpio_pad_out(pad_out1),
    .core_gpio_out(core_out1), .core_gpio_in(core_in1),
    .jtag_extest_active(ext1)
  );

  // 0 = boundary chain, 1 = IDCODE, 2 = BYPASS
  function automatic int m_chain();
    if (m_ins == 4'h1 || m_ins == 4'h2) return 0;
    if (m_ins == 4'h3 && HAS_ID) return 1;
    return 2;
  endfunction

  function automatic logic m_tdo();
    if (ms == T_SHIFT_IR) return m_irs[0];
    if (ms == T_SHIFT_DR) begin
      case (m_chain())
        0: return m_bsr[0];
        1: return m_id[0];
        default: return m_byp;
      endcase
    end
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] exp_pad_out();
    return (m_ins == 4'h1) ? m_upd[2*N-1:N] : core_gpio_out;
  endfunction

  function automatic logic [N-1:0] exp_core_in();
    return (m_ins == 4'h1) ? m_upd[N-1:0] : gpio_pad_in;
  endfunction

  task automatic model_reset();
    ms = T_RESET; m_irs = '0; m_ins = M_DEF; m_bsr = '0; m_upd = '0; m_id = '0; m_byp = 1'b0;
  endtask

  task automatic model_strobe(input bit tms, input bit tdi);
    int nxt;
    nxt = graph[ms][tms];
    case (ms)
      T_CAP_IR:   m_irs = 4'b0101;
      T_SHIFT_IR: m_irs = (m_irs >> 1) | (4'(tdi) << 3);
      T_UPD_IR:   m_ins = m_irs;
      T_CAP_DR: begin
        case (m_chain())
          0: m_bsr = {core_gpio_out, gpio_pad_in};
          1: m_id  = IDV | 32'd1;
          default: m_byp = 1'b0;
        endcase
      end
      T_SHIFT_DR: begin
        case (m_chain())
          0: m_bsr = (m_bsr >> 1) | ((2*N)'(tdi) << (2*N-1));
          1: m_id  = (m_id >> 1) | (32'(tdi) << 31);
          default: m_byp = tdi;
        endcase
      end
      T_UPD_DR: if (m_chain() == 0) m_upd = m_bsr;
      default: ;
    endcase
    if (nxt == T_RESET) begin
      m_ins = M_DEF;
      m_upd = '0;
    end
    ms = nxt;
  endtask

  task automatic strobe(input bit tms, input bit tdi);
    jtag_mode = tms; jtag_tdi = tdi; jtag_tck_enable = 1'b1;
    @(posedge internal_clk);
    model_strobe(tms, tdi);
    @(negedge internal_clk);
    jtag_tck_enable = 1'b0;
    @(negedge internal_clk);
  endtask

  task automatic reset_tap();
    repeat (5) strobe(1'b1, 1'b0);
  endtask

  task automatic to_shift_dr();
    strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b0, 1'b0);
  endtask

  task automatic to_shift_ir();
    strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b0, 1'b0);
  endtask

  task automatic finish_update();
    strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
  endtask

  task automatic shift_bits(input int n, input logic [31:0] din, input bit last_exit,
                            output logic [31:0] dout, output logic [31:0] dout1);
    dout = '0; dout1 = '0;
    for (int i = 0; i < n; i++) begin
      dout[i]  = jtag_tdo;
      dout1[i] = tdo1;
      strobe(last_exit && (i == n - 1), din[i]);
    end
  endtask

  task automatic load_ir(input logic [3:0] op);
    logic [31:0] d, d1;
    to_shift_ir();
    shift_bits(4, {28'd0, op}, 1'b1, d, d1);
    finish_update();
  endtask

  task automatic test_reset();
    @(negedge internal_clk);
    jtag_rstn = 1'b0; jtag_tck_enable = 1'b0;
    gpio_pad_in = 4'(($urandom)); core_gpio_out = 4'(($urandom));
    model_reset();
    #1;
    vectors++; if (jtag_tdo !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tdo: got %b want 0", jtag_tdo); end
    vectors++; if (jtag_extest_active !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_extest: got %b want 0", jtag_extest_active); end
    vectors++; if (gpio_pad_out !== core_gpio_out) begin miscompares++; $display("[TB] FAIL reset_pad_out: got %h want %h", gpio_pad_out, core_gpio_out); end
    vectors++; if (core_gpio_in !== gpio_pad_in) begin miscompares++; $display("[TB] FAIL reset_core_in: got %h want %h", core_gpio_in, gpio_pad_in); end
    repeat (2) @(negedge internal_clk);
    jtag_rstn = 1'b1;
    repeat (2) @(negedge internal_clk);
  endtask

  task automatic test_release_strobe();
    @(negedge internal_clk);
    jtag_rstn = 1'b0; model_reset();
    repeat (2) @(negedge internal_clk);
    jtag_rstn = 1'b1; jtag_mode = 1'b0; jtag_tck_enable = 1'b1;
    @(negedge internal_clk);
    jtag_tck_enable = 1'b0;
    @(negedge internal_clk);
    strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b0, 1'b0);
    vectors++; if (jtag_tdo !== m_tdo()) begin miscompares++; $display("[TB] FAIL release_strobe_tdo: got %b want %b", jtag_tdo, m_tdo()); end
  endtask

  task automatic test_idcode_scan();
    logic [31:0] din, d, d1, want;
    din = $urandom;
    reset_tap(); strobe(1'b0, 1'b0); to_shift_dr();
    shift_bits(32, din, 1'b1, d, d1);
    want = HAS_ID ? IDV : {din[30:0], 1'b0};
    vectors++; if (d !== want) begin miscompares++; $display("[TB] FAIL idcode_scan: got %h want %h", d, want); end
    vectors++; if (jtag_tdo !== 1'b0) begin miscompares++; $display("[TB] FAIL tdo_after_exit: got %b want 0", jtag_tdo); end
    finish_update();
  endtask

  task automatic test_ir_capture();
    logic [31:0] d, d1;
    to_shift_ir();
    shift_bits(4, 32'hF, 1'b1, d, d1);
    vectors++; if (d[3:0] !== 4'b0101) begin miscompares++; $display("[TB] FAIL ir_capture: got %b want 0101", d[3:0]); end
    finish_update();
    vectors++; if (jtag_extest_active !== 1'b0) begin miscompares++; $display("[TB] FAIL bypass_extest: got %b want 0", jtag_extest_active); end
  endtask

  task automatic test_bypass();
    logic [31:0] d, d1;
    to_shift_dr();
    shift_bits(4, 32'b1101, 1'b1, d, d1);
    vectors++; if (d[3:0] !== 4'b1010) begin miscompares++; $display("[TB] FAIL bypass_delay: got %b want 1010", d[3:0]); end
    finish_update();
  endtask

  task automatic test_sample_preload();
    logic [31:0] d, d1;
    gpio_pad_in = 4'hA; core_gpio_out = 4'h5; pad_in1 = 1'b1; core_out1 = 1'b1;
    load_ir(4'h2);
    to_shift_dr();
    shift_bits(8, 32'h3C, 1'b1, d, d1);
    vectors++; if (d[7:0] !== 8'h5A) begin miscompares++; $display("[TB] FAIL sample_capture: got %h want 5a", d[7:0]); end
    vectors++; if (d1[7:0] !== 8'hF3) begin miscompares++; $display("[TB] FAIL sample_capture_n1: got %h want f3", d1[7:0]); end
    finish_update();
    vectors++; if (gpio_pad_out !== 4'h5) begin miscompares++; $display("[TB] FAIL preload_pad_out: got %h want 5", gpio_pad_out); end
    vectors++; if (core_gpio_in !== 4'hA) begin miscompares++; $display("[TB] FAIL preload_core_in: got %h want a", core_gpio_in); end
  endtask

  task automatic test_extest();
    load_ir(4'h1);
    vectors++; if (gpio_pad_out !== 4'h3) begin miscompares++; $display("[TB] FAIL extest_pad_out: got %h want 3", gpio_pad_out); end
    vectors++; if (core_gpio_in !== 4'hC) begin miscompares++; $display("[TB] FAIL extest_core_in: got %h want c", core_gpio_in); end
    vectors++; if (jtag_extest_active !== 1'b1) begin miscompares++; $display("[TB] FAIL extest_flag: got %b want 1", jtag_extest_active); end
    vectors++; if (pad_out1 !== 1'b0 || core_in1 !== 1'b0) begin miscompares++; $display("[TB] FAIL extest_n1: got %b/%b want 0/0", pad_out1, core_in1); end
    reset_tap();
    vectors++; if (gpio_pad_out !== 4'h5) begin miscompares++; $display("[TB] FAIL tlr_pad_out: got %h want 5", gpio_pad_out); end
    vectors++; if (core_gpio_in !== 4'hA) begin miscompares++; $display("[TB] FAIL tlr_core_in: got %h want a", core_gpio_in); end
    vectors++; if (jtag_extest_active !== 1'b0) begin miscompares++; $display("[TB] FAIL tlr_flag: got %b want 0", jtag_extest_active); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] din, d, d1, want;
    strobe(1'b0, 1'b0);
    load_ir(4'h2); to_shift_dr(); shift_bits(8, 32'hC3, 1'b1, d, d1); finish_update();
    load_ir(4'h1); to_shift_dr(); shift_bits(4, 32'h0, 1'b0, d, d1);
    vectors++; if (jtag_tdo !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_tdo: got %b want 1", jtag_tdo); end
    jtag_rstn = 1'b0; model_reset();
    #1;
    vectors++; if (jtag_tdo !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_tdo: got %b want 0", jtag_tdo); end
    vectors++; if (jtag_extest_active !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_flag: got %b want 0", jtag_extest_active); end
    vectors++; if (gpio_pad_out !== core_gpio_out || core_gpio_in !== gpio_pad_in) begin
      miscompares++; $display("[TB] FAIL midreset_passthru: got %h/%h want %h/%h", gpio_pad_out, core_gpio_in, core_gpio_out, gpio_pad_in);
    end
    repeat (2) @(negedge internal_clk);
    jtag_rstn = 1'b1;
    repeat (2) @(negedge internal_clk);
    din = $urandom;
    strobe(1'b0, 1'b0); to_shift_dr();
    shift_bits(32, din, 1'b1, d, d1);
    want = HAS_ID ? IDV : {din[30:0], 1'b0};
    vectors++; if (d !== want) begin miscompares++; $display("[TB] FAIL rescan_idcode: got %h want %h", d, want); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      gpio_pad_in = 4'(($urandom)); core_gpio_out = 4'(($urandom));
      #1;
      vectors++; if (jtag_tdo !== m_tdo()) begin miscompares++; $display("[TB] FAIL rnd_tdo[%0d]: got %b want %b", k, jtag_tdo, m_tdo()); end
      vectors++; if (gpio_pad_out !== exp_pad_out()) begin miscompares++; $display("[TB] FAIL rnd_pad_out[%0d]: got %h want %h", k, gpio_pad_out, exp_pad_out()); end
      vectors++; if (core_gpio_in !== exp_core_in()) begin miscompares++; $display("[TB] FAIL rnd_core_in[%0d]: got %h want %h", k, core_gpio_in, exp_core_in()); end
      vectors++; if (jtag_extest_active !== (m_ins == 4'h1)) begin miscompares++; $display("[TB] FAIL rnd_flag[%0d]: got %b want %b", k, jtag_extest_active, (m_ins == 4'h1)); end
      strobe($urandom_range(0, 99) < 40, 1'($urandom));
      if ($urandom_range(0, 7) == 0) @(negedge internal_clk);
    end
  endtask

  initial begin
    jtag_rstn = 1'b0; jtag_tck_enable = 1'b0; jtag_mode = 1'b0; jtag_tdi = 1'b0;
    gpio_pad_in = '0; core_gpio_out = '0; pad_in1 = '0; core_out1 = '0;
    model_reset();
    test_reset();
    test_release_strobe();
    test_idcode_scan();
    test_ir_capture();
    test_bypass();
    test_sample_preload();
    test_extest();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
